// File: rtl/dsp_frame_sequencer_if.sv
// dsp_frame_sequencer_if: input frame, output frame and core tick/ready bundle.
// master drives frames in and plays the core; slave is the sequencer.
interface dsp_frame_sequencer_if #(
  parameter int data_width    = 16,
  parameter int n_io_channels = 2
);
  localparam int fw = n_io_channels * data_width;
  localparam int cw = (n_io_channels > 1) ? $clog2(n_io_channels) : 1;

  logic [fw-1:0]         in_frame;
  logic                  in_valid;
  logic                  in_ready;
  logic [fw-1:0]         out_frame;
  logic                  out_valid;
  logic                  out_ready;
  logic                  core_tick;
  logic [data_width-1:0] core_sample_in;
  logic [cw-1:0]         core_channel;
  logic [data_width-1:0] core_sample_out;
  logic                  core_ready;

  modport master (
    output in_frame, in_valid, out_ready,
    output core_sample_out, core_ready,
    input  in_ready, out_frame, out_valid,
    input  core_tick, core_sample_in, core_channel
  );

  modport slave (
    input  in_frame, in_valid, out_ready,
    input  core_sample_out, core_ready,
    output in_ready, out_frame, out_valid,
    output core_tick, core_sample_in, core_channel
  );
endinterface

// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: frame FIFO feeding a tick/ready core channel by channel.
// Define DSP_FRAME_SEQ_TIMEOUT_EN to add a core_ready watchdog that faults.
module dsp_frame_sequencer #(
  parameter int data_width     = 16,
  parameter int n_io_channels  = 2,
  parameter int fifo_depth     = 4,
  parameter int timeout_cycles = 4096,
  parameter int ctr_width      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 full_reset,
  input  logic                 enable,
  dsp_frame_sequencer_if.slave bus,
  output logic                 error,
  output logic [ctr_width-1:0] overrun_count,
  output logic [ctr_width-1:0] frames_done,
  output logic                 busy
);
  localparam int fw = n_io_channels * data_width;
  localparam int cw = (n_io_channels > 1) ? $clog2(n_io_channels) : 1;
  localparam int aw = $clog2(fifo_depth);

  typedef enum logic [2:0] {
    IDLE, ISSUE, SETTLE, WAIT, OUTPUT, FAULT
  } state_t;

  state_t        state;
  logic [fw-1:0] mem [fifo_depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic [aw:0]   count;
  logic [aw:0]   count_nxt;
  logic [fw-1:0] frame_q;
  logic [fw-1:0] result_q;
  logic [fw-1:0] res_nxt;
  logic [fw-1:0] head;
  logic [cw-1:0] ch;
  logic [cw-1:0] ch_nxt;
  logic          rst;
  logic          push;
  logic          pop;
  logic          last_ch;
  logic          timed_out;

  assign rst     = reset | full_reset;
  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = (state == IDLE) & (count != '0);
  assign head    = mem[rd_ptr];
  assign last_ch = (ch == cw'(n_io_channels - 1));
  assign ch_nxt  = ch + cw'(1);
  assign busy    = (state != IDLE);
  assign count_nxt = count + (aw+1)'(push) - (aw+1)'(pop);

  always_comb begin
    res_nxt = result_q;
    res_nxt[ch*data_width +: data_width] = bus.core_sample_out;
  end

`ifdef DSP_FRAME_SEQ_TIMEOUT_EN
  localparam int tw = $clog2(timeout_cycles + 1);
  logic [tw-1:0] wait_cnt;

  // Zero outside WAIT, so it starts cleared on every WAIT entry.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wait_cnt <= '0;
    else                      wait_cnt <= wait_cnt + tw'(1);
  end

  assign timed_out = (wait_cnt == tw'(timeout_cycles - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_frame;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.in_ready       <= 1'b1;
      frame_q            <= '0;
      result_q           <= '0;
      ch                 <= '0;
      bus.out_frame      <= '0;
      bus.out_valid      <= 1'b0;
      bus.core_tick      <= 1'b0;
      bus.core_sample_in <= '0;
      bus.core_channel   <= '0;
      error              <= 1'b0;
      overrun_count      <= '0;
      frames_done        <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop)  rd_ptr <= rd_ptr + aw'(1);
      count        <= count_nxt;
      bus.in_ready <= (count_nxt != (aw+1)'(fifo_depth));
      if (bus.in_valid && !bus.in_ready && overrun_count != '1)
        overrun_count <= overrun_count + ctr_width'(1);
      bus.core_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            frame_q <= head;
            ch      <= '0;
            if (enable) begin
              bus.core_tick      <= 1'b1;
              bus.core_sample_in <= head[data_width-1:0];
              bus.core_channel   <= '0;
              state              <= ISSUE;
            end else begin
              bus.out_frame <= head;
              bus.out_valid <= 1'b1;
              state         <= OUTPUT;
            end
          end
        end
        ISSUE:  state <= SETTLE;
        // Core ready lags the tick by a cycle; skip that stale value.
        SETTLE: state <= WAIT;
        WAIT: begin
          if (bus.core_ready) begin
            result_q <= res_nxt;
            if (last_ch) begin
              bus.out_frame <= res_nxt;
              bus.out_valid <= 1'b1;
              state         <= OUTPUT;
            end else begin
              ch                 <= ch_nxt;
              bus.core_tick      <= 1'b1;
              bus.core_sample_in <= frame_q[ch_nxt*data_width +: data_width];
              bus.core_channel   <= ch_nxt;
              state              <= ISSUE;
            end
          end else if (timed_out) begin
            error <= 1'b1;
            state <= FAULT;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (frames_done != '1)
              frames_done <= frames_done + ctr_width'(1);
            state <= IDLE;
          end
        end
        FAULT: begin
          error         <= 1'b1;
          bus.out_valid <= 1'b0;
        end
        default: begin
          error         <= 1'b1;
          bus.out_valid <= 1'b0;
          state         <= FAULT;
        end
      endcase
    end
  end
endmodule
